// File: rtl/key_entry.sv
// Keypad key entry: debounces decoded scan frames into one event per keystroke,
// collects BCD digits into an entry register and hands entries off over valid/ready.
module key_entry #(
  parameter int DEB_FRAMES = 3,
  parameter int DIGITS     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  scan_en,
  input  logic                  frame_start,
  input  logic                  press,
  input  logic [3:0]            scan_code,
  input  logic                  clear,
  input  logic                  enter,
  output logic                  key_evt,
  output logic [3:0]            key_val,
  output logic [4*DIGITS-1:0]   digits,
  output logic [2:0]            count,
  output logic                  overflow,
  output logic                  out_valid,
  output logic [4*DIGITS-1:0]   out_data,
  input  logic                  out_ready
);

  localparam logic [3:0] DEB_LAST = 4'(DEB_FRAMES);
  localparam logic [2:0] DIG_MAX  = 3'(DIGITS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONFIRM = 2'd1,
    HELD    = 2'd2,
    RELEASE = 2'd3
  } deb_state_t;

  // Debounce state is kept as a named signal so checkers can bind to it.
  deb_state_t deb_state;
  logic [3:0] cnt;
  logic [3:0] cand;
  logic [3:0] cnt_inc;

  logic       acc_has;
  logic       acc_conf;
  logic [3:0] acc_code;
  logic       slot_key;
  logic       frame_digit;

  logic                enter_ok;
  logic [4*DIGITS-1:0] key_ext;
  logic [4*DIGITS-1:0] digits_shift;

  // Codes above 9 are treated as if no key were pressed in that slot.
  assign slot_key    = scan_en && press && (scan_code <= 4'd9);
  assign frame_digit = acc_has && !acc_conf;
  assign cnt_inc     = cnt + 4'd1;

  assign enter_ok     = enter && (count != 3'd0) && !out_valid;
  assign key_ext      = (4*DIGITS)'(key_val);
  assign digits_shift = (digits << 4) | key_ext;

  // Frame accumulator; a slot arriving with frame_start opens the new frame.
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_has  <= 1'b0;
      acc_conf <= 1'b0;
      acc_code <= 4'd0;
    end else if (frame_start) begin
      acc_has  <= slot_key;
      acc_conf <= 1'b0;
      acc_code <= scan_code;
    end else if (slot_key) begin
      if (!acc_has) begin
        acc_has  <= 1'b1;
        acc_code <= scan_code;
      end else if (scan_code != acc_code) begin
        acc_conf <= 1'b1;
      end
    end
  end

  // Debounce FSM, stepped once per closed frame.
  always_ff @(posedge clk) begin
    if (!reset) begin
      deb_state <= IDLE;
      cnt       <= 4'd0;
      cand      <= 4'd0;
      key_evt   <= 1'b0;
      key_val   <= 4'hF;
    end else begin
      key_evt <= 1'b0;
      if (frame_start) begin
        case (deb_state)
          IDLE: begin
            if (frame_digit) begin
              cand      <= acc_code;
              cnt       <= 4'd1;
              deb_state <= CONFIRM;
            end
          end
          CONFIRM: begin
            if (!frame_digit) begin
              deb_state <= IDLE;
            end else if (acc_code == cand) begin
              cnt <= cnt_inc;
              if (cnt_inc == DEB_LAST) begin
                deb_state <= HELD;
                key_val   <= cand;
                key_evt   <= 1'b1;
              end
            end else begin
              cand <= acc_code;
              cnt  <= 4'd1;
            end
          end
          HELD: begin
            if (!frame_digit) begin
              cnt       <= 4'd1;
              deb_state <= RELEASE;
            end
          end
          RELEASE: begin
            if (frame_digit) begin
              deb_state <= HELD;
            end else begin
              cnt <= cnt_inc;
              if (cnt_inc == DEB_LAST) deb_state <= IDLE;
            end
          end
          default: deb_state <= IDLE;
        endcase
      end
    end
  end

  // Entry register and output hand-off. Handshake: out_data is offered while
  // out_valid is high and held stable; an edge with out_valid && out_ready
  // retires it, and no new entry is captured until then.
  always_ff @(posedge clk) begin
    if (!reset) begin
      digits    <= '0;
      count     <= 3'd0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (clear) begin
        digits   <= '0;
        count    <= 3'd0;
        overflow <= 1'b0;
      end else begin
        if (enter_ok) begin
          out_data  <= digits;
          out_valid <= 1'b1;
        end
        if (key_evt) begin
          if (enter_ok) begin
            // The captured entry excludes this digit; it starts the next one.
            digits   <= key_ext;
            count    <= 3'd1;
            overflow <= 1'b0;
          end else if (count < DIG_MAX) begin
            digits <= digits_shift;
            count  <= count + 3'd1;
          end else begin
            overflow <= 1'b1;
          end
        end else if (enter_ok) begin
          digits   <= '0;
          count    <= 3'd0;
          overflow <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_key_entry.sv
// Directed bench for key_entry: frame-level stimulus with a queue-based
// scoreboard for key events and output hand-offs.
module tb_key_entry;

  localparam int DEB_FRAMES = 3;
  localparam int DIGITS     = 4;
  localparam int W          = 4 * DIGITS;
  localparam logic [3:0] NK = 4'hF;

  logic         clk = 1'b0;
  logic         reset;
  logic         scan_en;
  logic         frame_start;
  logic         press;
  logic [3:0]   scan_code;
  logic         clear;
  logic         enter;
  logic         key_evt;
  logic [3:0]   key_val;
  logic [W-1:0] digits;
  logic [2:0]   count;
  logic         overflow;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;

  logic [3:0]   exp_key_q[$];
  logic [W-1:0] exp_q[$];
  int           seq[$];
  int           n_checks = 0;
  int           n_fail   = 0;

  // Clock / reset
  always #5 clk = ~clk;

  key_entry #(.DEB_FRAMES(DEB_FRAMES), .DIGITS(DIGITS)) dut (
    .clk(clk), .reset(reset), .scan_en(scan_en), .frame_start(frame_start),
    .press(press), .scan_code(scan_code), .clear(clear), .enter(enter),
    .key_evt(key_evt), .key_val(key_val), .digits(digits), .count(count),
    .overflow(overflow), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Monitor: pops expected responses whenever the DUT presents an output.
  always @(negedge clk) begin
    if (reset) begin
      if (key_evt) begin
        if (exp_key_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL key_evt: unexpected event with key_val %0h, expected none", key_val);
        end else begin
          check("key_val", 32'(key_val), 32'(exp_key_q.pop_front()));
        end
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL out_valid: unexpected with out_data %0h, expected none", out_data);
        end else begin
          check("out_data", 32'(out_data), 32'(exp_q[0]));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One scan frame: four slots, row 0 carries frame_start; NK means no press.
  task automatic frame(input logic [3:0] c0, input logic [3:0] c1);
    for (int s = 0; s < 4; s++) begin
      frame_start = (s == 0);
      scan_en     = 1'b1;
      press       = (s == 0 && c0 != NK) || (s == 1 && c1 != NK);
      scan_code   = (s == 0) ? c0 : (s == 1) ? c1 : 4'h0;
      tick();
      frame_start = 1'b0;
      scan_en     = 1'b0;
      press       = 1'b0;
      tick();
    end
  endtask

  // Plays seq (15 = empty frame, key in row 1); expects an event before frame evt_at.
  task automatic play_seq(input int evt_at, input logic [3:0] evt_val);
    for (int i = 0; i < seq.size(); i++) begin
      if (i == evt_at) exp_key_q.push_back(evt_val);
      frame(NK, 4'(seq[i]));
    end
    seq.delete();
  endtask

  task automatic hold_key(input logic [3:0] k, input int n_on);
    for (int i = 0; i < n_on; i++) seq.push_back(int'(k));
    for (int i = 0; i < DEB_FRAMES + 1; i++) seq.push_back(15);
    play_seq((n_on >= DEB_FRAMES) ? DEB_FRAMES : -1, k);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
  endtask

  task automatic pulse_enter();
    enter = 1'b1;
    tick();
    enter = 1'b0;
    tick();
  endtask

  task automatic check_entry(input logic [W-1:0] d, input logic [2:0] c, input logic o);
    @(negedge clk);
    check("digits", 32'(digits), 32'(d));
    check("count", 32'(count), 32'(c));
    check("overflow", 32'(overflow), 32'(o));
    check("no pending key event", exp_key_q.size(), 0);
  endtask

  task automatic check_reset_values();
    @(negedge clk);
    check("reset key_evt", 32'(key_evt), 0);
    check("reset key_val", 32'(key_val), 32'hF);
    check("reset digits", 32'(digits), 0);
    check("reset count", 32'(count), 0);
    check("reset overflow", 32'(overflow), 0);
    check("reset out_valid", 32'(out_valid), 0);
    check("reset out_data", 32'(out_data), 0);
  endtask

  initial begin
    reset = 1'b0; scan_en = 1'b0; frame_start = 1'b0; press = 1'b0;
    scan_code = 4'h0; clear = 1'b0; enter = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    check_reset_values();
    tick();
    reset = 1'b1;
    tick();

    // Long hold then release: one event each
    hold_key(4'd5, 6);
    check_entry(16'h0005, 3'd1, 1'b0);
    hold_key(4'd5, 3);
    check_entry(16'h0055, 3'd2, 1'b0);

    // Short burst does not confirm; second burst does
    seq = {7, 7, 15, 7, 7, 7, 15, 15, 15, 15};
    play_seq(6, 4'd7);
    check_entry(16'h0557, 3'd3, 1'b0);
    seq = {7, 15, 7, 7, 7, 15, 15, 15, 15};
    play_seq(5, 4'd7);
    check_entry(16'h5577, 3'd4, 1'b0);
    pulse_clear();
    check_entry(16'h0000, 3'd0, 1'b0);

    // Fill past capacity
    hold_key(4'd1, 3);
    hold_key(4'd2, 3);
    hold_key(4'd3, 3);
    hold_key(4'd4, 3);
    hold_key(4'd9, 3);
    check_entry(16'h1234, 3'd4, 1'b1);
    pulse_clear();
    check_entry(16'h0000, 3'd0, 1'b0);

    // Hand-off with consumer stalled
    hold_key(4'd4, 3);
    hold_key(4'd2, 3);
    check_entry(16'h0042, 3'd2, 1'b0);
    exp_q.push_back(16'h0042);
    pulse_enter();
    repeat (5) tick();
    @(negedge clk);
    check("out_valid while stalled", 32'(out_valid), 1);
    check_entry(16'h0000, 3'd0, 1'b0);
    hold_key(4'd6, 3);
    pulse_enter();
    check_entry(16'h0006, 3'd1, 1'b0);
    check("out_valid after ignored enter", 32'(out_valid), 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    check("out_valid after accept", 32'(out_valid), 0);
    check("hand-off consumed", exp_q.size(), 0);
    pulse_clear();

    // Two keys in one frame, and an out-of-range code, are no key
    for (int i = 0; i < 4; i++) frame(4'd1, 4'd5);
    for (int i = 0; i < 4; i++) frame(NK, NK);
    for (int i = 0; i < 4; i++) frame(NK, 4'hC);
    for (int i = 0; i < 4; i++) frame(NK, NK);
    check_entry(16'h0000, 3'd0, 1'b0);
    // Row-0 key with an out-of-range code beside it still confirms
    for (int i = 0; i < 7; i++) begin
      if (i == 3) exp_key_q.push_back(4'd1);
      if (i < 3) frame(4'd1, 4'hC);
      else frame(NK, NK);
    end
    check_entry(16'h0001, 3'd1, 1'b0);
    clear = 1'b1;
    enter = 1'b1;
    tick();
    clear = 1'b0;
    enter = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    check("out_valid after clear+enter", 32'(out_valid), 0);
    check_entry(16'h0000, 3'd0, 1'b0);

    // Reset mid-confirm with a pending hand-off
    hold_key(4'd4, 3);
    exp_q.push_back(16'h0004);
    pulse_enter();
    for (int i = 0; i < 3; i++) frame(NK, 4'd8);
    @(negedge clk);
    check("out_valid before reset", 32'(out_valid), 1);
    reset = 1'b0;
    tick();
    tick();
    exp_q.delete();
    exp_key_q.delete();
    check_reset_values();
    tick();
    reset = 1'b1;
    tick();
    hold_key(4'd8, 3);
    check_entry(16'h0008, 3'd1, 1'b0);

    check("final key queue empty", exp_key_q.size(), 0);
    check("final output queue empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
